// File: rtl/param_dwn_cntr_pkg.sv
// param_dwn_cntr_pkg
// Shared types and constants for the parametrised down-counter
// (param_dwn_cntr) and its optional prescaler.
package param_dwn_cntr_pkg;

    // Counter state. IDLE means count==0 and no countdown in progress.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Values of the mode input / mode_q register.
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Width of a counter that runs 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : param_dwn_cntr_pkg

// File: rtl/param_dwn_cntr_prescaler.sv
// param_dwn_cntr_prescaler
// Divides enabled RUN cycles by PRESCALE. The counter runs 0..PRESCALE-1
// and tick is asserted on the enabled cycle in which it wraps, so a tick
// is produced once every PRESCALE enabled cycles. restart zeroes the
// phase so a fresh countdown always starts a full prescale period.
// Used only when PARAM_DWN_CNTR_PRESCALE_EN is defined.
module param_dwn_cntr_prescaler
    import param_dwn_cntr_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int              CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    // Wrap indication is combinational so the tick lines up with the
    // enabled cycle that completes the prescale period.
    assign tick = en && (phase == LAST);

    // Phase counter: cleared on restart, advances on enabled cycles.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (restart) begin
            phase <= '0;
        end else if (en) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule : param_dwn_cntr_prescaler

// File: rtl/param_dwn_cntr.sv
// param_dwn_cntr
// Loadable WIDTH-bit down-counter with a one-cycle terminal-count pulse
// (CO), one-shot or periodic (auto-reload) operation, count enable and
// synchronous clear. Used as the bit-period and frame timer under the
// UART transmit/receive timing logic.
//
// Priority on every clock edge: reset > clear > load > decrement.
//
// Optional build macro PARAM_DWN_CNTR_PRESCALE_EN: when defined, a
// decrement happens only once every PRESCALE enabled RUN cycles; when
// undefined every enabled RUN cycle decrements and PRESCALE is ignored.
module param_dwn_cntr
    import param_dwn_cntr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             CO,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic             mode_q;
    logic             tick;

`ifdef PARAM_DWN_CNTR_PRESCALE_EN
    logic run_en;
    logic restart;

    // The prescaler only advances while actually counting, and its phase
    // is discarded on clear, load and whenever the counter is idle.
    assign run_en  = enable && (state == RUN);
    assign restart = clear || load || (state == IDLE);

    param_dwn_cntr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLOCK   (CLOCK),
        .reset   (reset),
        .restart (restart),
        .en      (run_en),
        .tick    (tick)
    );
`else
    // Without the prescaler every enabled cycle is a decrement tick.
    // PRESCALE has no effect here; the term is true for any legal value.
    assign tick = enable && (PRESCALE >= 1);
`endif

    // busy follows the registered state directly.
    assign busy = (state == RUN);

    // Main counter: clear/load/decrement with registered CO pulse.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode_q <= MODE_ONESHOT;
            CO     <= 1'b0;
        end else if (clear) begin
            // reload and mode_q are deliberately kept across a clear.
            state <= IDLE;
            count <= '0;
            CO    <= 1'b0;
        end else if (load) begin
            // A load restarts the countdown from any state; loading zero
            // parks the counter in IDLE without a terminal pulse.
            reload <= load_value;
            mode_q <= mode;
            count  <= load_value;
            CO     <= 1'b0;
            state  <= (load_value != '0) ? RUN : IDLE;
        end else if ((state == RUN) && tick) begin
            if (count > ONE) begin
                count <= count - ONE;
                CO    <= 1'b0;
            end else if (count == ONE) begin
                // Terminal count: CO is high in the cycle the terminal
                // value (0, or reload when periodic) becomes visible.
                CO <= 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                    count <= reload;
                end else begin
                    count <= '0;
                    state <= IDLE;
                end
            end else begin
                // count==0 in RUN cannot arise from a load or reload;
                // fall back to IDLE rather than wrapping below zero.
                count <= '0;
                CO    <= 1'b0;
                state <= IDLE;
            end
        end else begin
            // Paused in RUN, or idle: count holds and the pulse ends.
            CO <= 1'b0;
        end
    end

endmodule : param_dwn_cntr

// File: tb/tb_param_dwn_cntr.sv
// tb_param_dwn_cntr
// Self-checking bench for param_dwn_cntr: an 8-bit instance compared every
// cycle against a behavioural model, directed scenarios with hand-computed
// values, and a 16-bit instance for the full-range periodic case.
module tb_param_dwn_cntr;

`ifdef PARAM_DWN_CNTR_PRESCALE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 1;
`endif
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic         reset      = 1'b0;
    logic         clear      = 1'b0;
    logic         load       = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         mode       = 1'b0;
    logic         enable     = 1'b0;
    logic [W-1:0] count;
    logic         CO;
    logic         busy;

    logic         load16 = 1'b0;
    logic [15:0]  lv16   = '0;
    logic [15:0]  count16;
    logic         co16;
    logic         busy16;

    param_dwn_cntr #(.WIDTH(W), .PRESCALE(PRE)) dut (
        .CLOCK      (CLOCK),
        .reset      (reset),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .mode       (mode),
        .enable     (enable),
        .count      (count),
        .CO         (CO),
        .busy       (busy)
    );

    param_dwn_cntr #(.WIDTH(16), .PRESCALE(1)) dut16 (
        .CLOCK      (CLOCK),
        .reset      (reset),
        .clear      (1'b0),
        .load       (load16),
        .load_value (lv16),
        .mode       (1'b1),
        .enable     (1'b1),
        .count      (count16),
        .CO         (co16),
        .busy       (busy16)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Integer model of the counting rules: remaining count, reload value,
    // mode, running flag, enabled cycles since the last decrement.
    int m_count  = 0;
    int m_reload = 0;
    int m_pre    = 0;
    bit m_mode   = 1'b0;
    bit m_run    = 1'b0;
    bit m_co     = 1'b0;

    always @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            m_count <= 0; m_reload <= 0; m_pre <= 0;
            m_mode <= 1'b0; m_run <= 1'b0; m_co <= 1'b0;
        end else if (clear) begin
            m_count <= 0; m_co <= 1'b0; m_run <= 1'b0; m_pre <= 0;
        end else if (load) begin
            m_reload <= int'(load_value);
            m_mode   <= mode;
            m_count  <= int'(load_value);
            m_co     <= 1'b0;
            m_run    <= (load_value != 0);
            m_pre    <= 0;
        end else if (m_run && enable) begin
            if (m_pre == PRE - 1) begin
                m_pre <= 0;
                if (m_count == 1) begin
                    m_co <= 1'b1;
                    if (m_mode) begin
                        m_count <= m_reload;
                    end else begin
                        m_count <= 0;
                        m_run   <= 1'b0;
                    end
                end else begin
                    m_count <= m_count - 1;
                    m_co    <= 1'b0;
                end
            end else begin
                m_pre <= m_pre + 1;
                m_co  <= 1'b0;
            end
        end else begin
            m_co <= 1'b0;
            if (!m_run) m_pre <= 0;
        end
    end

    // Compare process: DUT vs model shortly after every active edge.
    bit cmp_on = 1'b0;
    always @(posedge CLOCK) begin
        #1;
        if (cmp_on) begin
            check("model_count", 32'(count), 32'(m_count));
            check("model_co",    32'(CO),    32'(m_co));
            check("model_busy",  32'(busy),  32'(m_run));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic do_load(input logic [W-1:0] v, input logic m);
        load_value = v;
        mode       = m;
        load       = 1'b1;
        @(negedge CLOCK);
        load       = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * PRE) @(negedge CLOCK);
    endtask

    // ---------------- stimulus ----------------
    int cyc;

    initial begin
        // Reset state
        reset = 1'b1;
        @(negedge CLOCK);
        check("rst_count", 32'(count), 32'd0);
        check("rst_co",    32'(CO),    32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        @(negedge CLOCK);
        reset  = 1'b0;
        cmp_on = 1'b1;

        // One-shot 5: 5,4,3,2,1,0 with CO only at 0, busy drops with it
        enable = 1'b1;
        do_load(8'd5, 1'b0);
        check("os_load_count", 32'(count), 32'd5);
        check("os_load_busy",  32'(busy),  32'd1);
        check("os_load_co",    32'(CO),    32'd0);
        for (int v = 4; v >= 0; v--) begin
            wait_ticks(1);
            check("os_count", 32'(count), 32'(v));
            check("os_co",    32'(CO),    32'(v == 0));
            check("os_busy",  32'(busy),  32'(v != 0));
        end
        @(negedge CLOCK);
        check("os_co_drop",   32'(CO),    32'd0);
        check("os_idle_hold", 32'(count), 32'd0);

        // Periodic 3: 3,2,1,3,2,1,... CO on each reload, busy stays 1
        do_load(8'd3, 1'b1);
        check("per_load_count", 32'(count), 32'd3);
        for (int k = 1; k <= 12; k++) begin
            wait_ticks(1);
            check("per_count", 32'(count), 32'(3 - (k % 3)));
            check("per_co",    32'(CO),    32'((k % 3) == 0));
            check("per_busy",  32'(busy),  32'd1);
        end

        // Pause at 7 for 4 cycles, then clear
        do_load(8'd10, 1'b0);
        wait_ticks(3);
        check("pause_at", 32'(count), 32'd7);
        enable = 1'b0;
        repeat (4) begin
            @(negedge CLOCK);
            check("pause_count", 32'(count), 32'd7);
            check("pause_co",    32'(CO),    32'd0);
        end
        clear = 1'b1;
        @(negedge CLOCK);
        clear  = 1'b0;
        enable = 1'b1;
        check("clr_count", 32'(count), 32'd0);
        check("clr_busy",  32'(busy),  32'd0);
        check("clr_co",    32'(CO),    32'd0);
        @(negedge CLOCK);
        check("clr_co_after", 32'(CO), 32'd0);

        // load_value == 0: stays IDLE, no pulse
        do_load(8'd0, 1'b0);
        check("ld0_count", 32'(count), 32'd0);
        check("ld0_busy",  32'(busy),  32'd0);
        check("ld0_co",    32'(CO),    32'd0);

        // Load 9 on the cycle count==1: load wins, no pulse
        do_load(8'd2, 1'b0);
        wait_ticks(1);
        check("ld1_pre", 32'(count), 32'd1);
        do_load(8'd9, 1'b0);
        check("ld1_count", 32'(count), 32'd9);
        check("ld1_co",    32'(CO),    32'd0);
        check("ld1_busy",  32'(busy),  32'd1);

        // clear together with load: clear wins
        clear = 1'b1;
        do_load(8'd6, 1'b1);
        clear = 1'b0;
        check("clrld_count", 32'(count), 32'd0);
        check("clrld_busy",  32'(busy),  32'd0);

        // Asynchronous reset mid-count at count==4
        do_load(8'd8, 1'b0);
        wait_ticks(4);
        check("arst_pre", 32'(count), 32'd4);
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_co",    32'(CO),    32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        @(negedge CLOCK);
        reset = 1'b0;

        // Reload one cycle into a countdown restarts the prescale phase:
        // terminal pulse arrives 2 full ticks after the second load
        do_load(8'd2, 1'b0);
        @(negedge CLOCK);
        do_load(8'd2, 1'b0);
        cyc = 0;
        while (!CO && cyc < 100) begin
            @(negedge CLOCK);
            cyc++;
        end
        check("restart_latency", 32'(cyc), 32'(2 * PRE));

        // 16-bit periodic 0xFFFF: first CO after 65535 cycles, reload
        lv16   = 16'hFFFF;
        load16 = 1'b1;
        @(negedge CLOCK);
        load16 = 1'b0;
        check("w16_load",  32'(count16), 32'h0000FFFF);
        check("w16_busy",  32'(busy16),  32'd1);
        @(negedge CLOCK);
        check("w16_first_dec", 32'(count16), 32'h0000FFFE);
        cyc = 1;
        while (!co16 && cyc < 70000) begin
            @(negedge CLOCK);
            cyc++;
        end
        check("w16_period", 32'(cyc),     32'd65535);
        check("w16_reload", 32'(count16), 32'h0000FFFF);
        check("w16_busy2",  32'(busy16),  32'd1);
        @(negedge CLOCK);
        check("w16_co_drop", 32'(co16), 32'd0);

        cmp_on = 1'b0;
        @(negedge CLOCK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_param_dwn_cntr

// File: doc/param_dwn_cntr.md
Name: param_dwn_cntr

Overview:
Parametrised down-counter with terminal-count pulse. Generalises the 8-bit loadable down counter used for UART bit/baud timing. Adds:
- WIDTH parameter
- one-shot or periodic (auto-reload) mode
- count enable and synchronous clear
- status outputs

It sits under the uart_tx/uart_rx timing logic as the bit-period and frame timer.

Parameters:
WIDTH, 8, counter and load_value width in bits (min 2)
PRESCALE, 1, decrement every PRESCALE enabled cycles (only with PARAM_DWN_CNTR_PRESCALE_EN; min 1)

Ports:
CLOCK  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
clear  input  1  synchronous clear, highest priority after reset
load  input  1  capture load_value into count and reload register
load_value  input  WIDTH  start/reload value
mode  input  1  0 = one-shot, 1 = periodic; sampled only when load=1
enable  input  1  count enable; 0 freezes count
count  output  WIDTH  current count value
CO  output  1  terminal-count pulse, one cycle
busy  output  1  1 while in RUN state

Behaviour:
- Decided: reset reset, asynchronous, active-high; clock CLOCK.
- On reset:
  - count=0, reload=0, mode_q=0, CO=0, busy=0, state=IDLE.
  - Prescaler (if present) = 0.
- States: IDLE (count==0, not running) and RUN.
- Priority each edge: reset > clear > load > decrement.
- clear: count=0, CO=0, state=IDLE; reload register and mode_q retained.
- load:
  - Sets reload=load_value, mode_q=mode, count=load_value, CO=0.
  - load_value!=0 -> RUN.
  - load_value==0 -> IDLE with no CO.
  - load accepted in any state, including mid-count (restart).
- RUN, enable=1 (decrement tick):
  - count>1: count-=1, CO=0.
  - count==1, one-shot: count=0, CO=1, state=IDLE.
  - count==1, periodic: count=reload, CO=1, stay RUN.
- RUN, enable=0: count holds, CO=0.
- IDLE: count holds at 0; CO=0 after the pulse cycle; enable ignored.
- CO timing:
  - Registered; high for exactly one cycle, the cycle in which count first shows the terminal value (0, or reload in periodic mode).
  - Period in periodic mode with enable held = reload cycles (×PRESCALE with the option).
- Simultaneous events:
  - load on the cycle count==1: load wins, CO stays 0.
  - clear with load: clear wins.
- busy = (state==RUN), registered with state.
- No wrap below zero; count never decrements from 0.
- Arithmetic is unsigned WIDTH-bit; no overflow possible.

Optional Feature:
PARAM_DWN_CNTR_PRESCALE_EN
- Defined:
  - A prescaler counts 0..PRESCALE-1 on enabled RUN cycles.
  - A decrement tick occurs only when the prescaler wraps.
  - The prescaler is zeroed by reset, clear, load, and on entering IDLE.
- Undefined:
  - Every enabled RUN cycle is a tick.
  - The PRESCALE parameter is ignored.

Decomposition:
- Package param_dwn_cntr_pkg holds:
  - state typedef (IDLE, RUN)
  - mode constants MODE_ONESHOT=0, MODE_PERIODIC=1
- One sub-module, param_dwn_cntr_prescaler:
  - Parameter PRESCALE.
  - Inputs: CLOCK, reset, restart, en. Output: tick.
  - Instantiated only under the macro; otherwise tick=enable.

Test Plan:
- One-shot, WIDTH=8: load_value=5, mode=0, enable=1 -> count 5,4,3,2,1,0; CO=1 only on the cycle count reads 0; busy drops the same cycle.
- Periodic: load_value=3, mode=1 -> CO pulses every 3 cycles for ≥4 periods; count sequence 3,2,1,3,2,1…; busy stays 1.
- Pause/clear: load 10, enable low for 4 cycles at count=7 -> count holds 7, CO=0; then clear -> count=0, busy=0, no CO.
- Boundaries:
  - load_value=0 -> IDLE, busy=0, no CO.
  - load 9 on the cycle count==1 -> count=9, CO=0.
  - reset asserted mid-count (count=4) -> all outputs 0 immediately.
- WIDTH=16: load 0xFFFF periodic -> first CO after 65535 cycles, count reloads to 0xFFFF.
- Macro defined, PRESCALE=4: load 2, mode=0 -> CO after 8 enabled cycles; load mid-prescale restarts the prescaler.
